// File: rtl/lz77_pkg.sv
// Shared definitions for the streaming LZ77 encoder.
// Holds the default parameter values, the encoder state enum, the token
// record used to describe one (offset, len, char, last) tuple at the
// default field widths, and a small integer helper.
package lz77_pkg;

    localparam int SYM_W_DEF      = 8;
    localparam int SEARCH_LEN_DEF = 9;
    localparam int LOOK_LEN_DEF   = 8;
    localparam int OFF_W_DEF      = $clog2(SEARCH_LEN_DEF);
    localparam int LEN_W_DEF      = $clog2(LOOK_LEN_DEF);
    localparam logic [7:0] EOS_CHAR_DEF = 8'h24;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_SEARCH,
        ST_EMIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [OFF_W_DEF-1:0] offset;
        logic [LEN_W_DEF-1:0] len;
        logic [SYM_W_DEF-1:0] chr;
        logic                 last;
    } token_t;

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/lz77_match_cmp.sv
// Combinational match-length comparator.
// The window is history (index 0 = oldest, SEARCH_LEN-1 = most recent)
// followed by the lookahead. A candidate at offset o starts at history
// index SEARCH_LEN-1-o and is compared symbol by symbol against the
// lookahead; the walk may run past the end of history into the lookahead,
// which is what allows overlapping matches.
// Ports:
//   win_i      packed window, symbol k at bits [k*SYM_W +: SYM_W]
//   cand_off_i candidate offset (0 = most recent history symbol)
//   lmax_i     cap on the returned length
//   len_o      number of leading equal symbols, capped at lmax_i
module lz77_match_cmp
    import lz77_pkg::*;
#(
    parameter int SYM_W      = SYM_W_DEF,
    parameter int SEARCH_LEN = SEARCH_LEN_DEF,
    parameter int LOOK_LEN   = LOOK_LEN_DEF,
    parameter int OFF_W      = $clog2(SEARCH_LEN),
    parameter int LEN_W      = $clog2(LOOK_LEN)
) (
    input  logic [(SEARCH_LEN+LOOK_LEN)*SYM_W-1:0] win_i,
    input  logic [OFF_W-1:0]                       cand_off_i,
    input  logic [LEN_W-1:0]                       lmax_i,
    output logic [LEN_W-1:0]                       len_o
);

    localparam int TOT = SEARCH_LEN + LOOK_LEN;

    logic [SYM_W-1:0] sym [TOT];
    logic [SYM_W-1:0] srcSym;
    logic             run;
    int               startIdx;

    for (genvar g = 0; g < TOT; g++) begin : g_unpack
        assign sym[g] = win_i[g*SYM_W +: SYM_W];
    end

    // The candidate symbol is picked by a compare-select over the whole
    // window so the sliding start index never needs a variable part-select.
    always_comb begin
        len_o    = '0;
        run      = 1'b1;
        srcSym   = '0;
        startIdx = SEARCH_LEN - 1 - int'(cand_off_i);
        for (int k = 0; k < LOOK_LEN - 1; k++) begin
            srcSym = '0;
            for (int j = 0; j < TOT; j++) begin
                if (j == startIdx + k) begin
                    srcSym = sym[j];
                end
            end
            if (run && (k < int'(lmax_i)) && (srcSym == sym[SEARCH_LEN + k])) begin
                len_o = LEN_W'(k + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder.
// Symbols arrive on a valid/ready stream terminated by in_last_i and are
// turned into (offset, len, char, last) tokens on a valid/ready stream.
// Flow: FILL tops up the lookahead, SEARCH scans one history offset per
// cycle from the oldest down to the most recent, EMIT holds the token until
// accepted, SHIFT moves the consumed symbols into history one per cycle,
// and DONE parks the block until reset.
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_valid_i/in_ready_o           input handshake
//   in_data_i, in_last_i            input symbol and end-of-stream flag
//   tok_valid_o/tok_ready_i         token handshake
//   tok_offset_o, tok_len_o         match distance-1 and match length
//   tok_char_o, tok_last_o          next symbol (or EOS_CHAR), final token
//   done_o                          high once the final token is taken
module lz77_stream_encoder
    import lz77_pkg::*;
#(
    parameter int SYM_W      = SYM_W_DEF,
    parameter int SEARCH_LEN = SEARCH_LEN_DEF,
    parameter int LOOK_LEN   = LOOK_LEN_DEF,
    parameter int OFF_W      = $clog2(SEARCH_LEN),
    parameter int LEN_W      = $clog2(LOOK_LEN),
    parameter logic [SYM_W-1:0] EOS_CHAR = SYM_W'(EOS_CHAR_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SYM_W-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             tok_valid_o,
    input  logic             tok_ready_i,
    output logic [OFF_W-1:0] tok_offset_o,
    output logic [LEN_W-1:0] tok_len_o,
    output logic [SYM_W-1:0] tok_char_o,
    output logic             tok_last_o,
    output logic             done_o
);

    localparam int HC_W  = $clog2(SEARCH_LEN + 1);
    localparam int LC_W  = $clog2(LOOK_LEN + 1);
    localparam int WIN_W = (SEARCH_LEN + LOOK_LEN) * SYM_W;

    state_e           state_q;
    logic [SYM_W-1:0] hist_q [SEARCH_LEN];
    logic [SYM_W-1:0] look_q [LOOK_LEN];
    logic [HC_W-1:0]  histCnt_q;
    logic [LC_W-1:0]  lookCnt_q;
    logic             eos_q;
    logic [OFF_W-1:0] cand_q;
    logic [OFF_W-1:0] bestOff_q;
    logic [LEN_W-1:0] bestLen_q;
    logic [LC_W-1:0]  shiftRem_q;
    logic             tokValid_q;
    logic [OFF_W-1:0] tokOffset_q;
    logic [LEN_W-1:0] tokLen_q;
    logic [SYM_W-1:0] tokChar_q;
    logic             tokLast_q;

    logic [WIN_W-1:0] window_d;
    logic [LEN_W-1:0] lmax_d;
    logic [LEN_W-1:0] candLen_d;
    logic [LEN_W-1:0] effLen_d;
    logic             better_d;
    logic [LEN_W-1:0] finLen_d;
    logic [OFF_W-1:0] finOff_d;
    logic [SYM_W-1:0] finChar_d;
    logic             finLast_d;
    logic [HC_W-1:0]  histInc_d;
    int               lookAvail_d;

    for (genvar g = 0; g < SEARCH_LEN; g++) begin : g_winHist
        assign window_d[g*SYM_W +: SYM_W] = hist_q[g];
    end
    for (genvar g = 0; g < LOOK_LEN; g++) begin : g_winLook
        assign window_d[(SEARCH_LEN+g)*SYM_W +: SYM_W] = look_q[g];
    end

    lz77_match_cmp #(
        .SYM_W     (SYM_W),
        .SEARCH_LEN(SEARCH_LEN),
        .LOOK_LEN  (LOOK_LEN),
        .OFF_W     (OFF_W),
        .LEN_W     (LEN_W)
    ) u_cmp (
        .win_i     (window_d),
        .cand_off_i(cand_q),
        .lmax_i    (lmax_d),
        .len_o     (candLen_d)
    );

    // Before end of stream the final lookahead slot is held back so the
    // token always has a real next symbol; once in_last has been seen the
    // whole lookahead may be matched and the char becomes EOS_CHAR.
    // The "fin" values fold the current candidate into the running best so
    // the token can be registered on the last SEARCH cycle.
    always_comb begin
        lookAvail_d = eos_q ? int'(lookCnt_q) : int'(lookCnt_q) - 1;
        if (lookAvail_d < 0) begin
            lookAvail_d = 0;
        end
        lmax_d    = LEN_W'(minInt(LOOK_LEN - 1, lookAvail_d));
        effLen_d  = (histCnt_q == '0) ? '0 : candLen_d;
        better_d  = (effLen_d > bestLen_q);
        finLen_d  = better_d ? effLen_d : bestLen_q;
        finOff_d  = better_d ? cand_q : bestOff_q;
        finChar_d = EOS_CHAR;
        for (int i = 0; i < LOOK_LEN; i++) begin
            if ((i == int'(finLen_d)) && (i < int'(lookCnt_q))) begin
                finChar_d = look_q[i];
            end
        end
        finLast_d = eos_q && ((int'(finLen_d) + 1) >= int'(lookCnt_q));
        histInc_d = (histCnt_q == HC_W'(SEARCH_LEN)) ? histCnt_q : histCnt_q + 1'b1;
    end

    assign in_ready_o   = (state_q == ST_FILL) && (lookCnt_q < LC_W'(LOOK_LEN)) && !eos_q;
    assign done_o       = (state_q == ST_DONE);
    assign tok_valid_o  = tokValid_q;
    assign tok_offset_o = tokOffset_q;
    assign tok_len_o    = tokLen_q;
    assign tok_char_o   = tokChar_q;
    assign tok_last_o   = tokLast_q;

    // Main encoder FSM. Every transition into SEARCH seeds the candidate
    // with the oldest valid history offset (using the post-shift history
    // count when coming from SHIFT) and clears the running best; only a
    // strictly longer match replaces the best, so ties keep the larger offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            histCnt_q   <= '0;
            lookCnt_q   <= '0;
            eos_q       <= 1'b0;
            cand_q      <= '0;
            bestOff_q   <= '0;
            bestLen_q   <= '0;
            shiftRem_q  <= '0;
            tokValid_q  <= 1'b0;
            tokOffset_q <= '0;
            tokLen_q    <= '0;
            tokChar_q   <= '0;
            tokLast_q   <= 1'b0;
            for (int i = 0; i < SEARCH_LEN; i++) hist_q[i] <= '0;
            for (int i = 0; i < LOOK_LEN; i++) look_q[i] <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if ((lookCnt_q == LC_W'(LOOK_LEN)) || eos_q) begin
                        state_q   <= ST_SEARCH;
                        cand_q    <= (histCnt_q == '0) ? '0 : OFF_W'(histCnt_q - 1'b1);
                        bestOff_q <= '0;
                        bestLen_q <= '0;
                    end else if (in_valid_i) begin
                        for (int i = 0; i < LOOK_LEN; i++) begin
                            if (i == int'(lookCnt_q)) look_q[i] <= in_data_i;
                        end
                        lookCnt_q <= lookCnt_q + 1'b1;
                        if (in_last_i) eos_q <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (cand_q == '0) begin
                        tokValid_q  <= 1'b1;
                        tokOffset_q <= finOff_d;
                        tokLen_q    <= finLen_d;
                        tokChar_q   <= finChar_d;
                        tokLast_q   <= finLast_d;
                        state_q     <= ST_EMIT;
                    end else begin
                        cand_q <= cand_q - 1'b1;
                        if (better_d) begin
                            bestLen_q <= effLen_d;
                            bestOff_q <= cand_q;
                        end
                    end
                end
                ST_EMIT: begin
                    if (tok_ready_i) begin
                        tokValid_q <= 1'b0;
                        shiftRem_q <= ((int'(tokLen_q) + 1) < int'(lookCnt_q)) ?
                                      LC_W'(int'(tokLen_q) + 1) : lookCnt_q;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    for (int i = 0; i < SEARCH_LEN - 1; i++) hist_q[i] <= hist_q[i+1];
                    hist_q[SEARCH_LEN-1] <= look_q[0];
                    for (int i = 0; i < LOOK_LEN - 1; i++) look_q[i] <= look_q[i+1];
                    lookCnt_q  <= lookCnt_q - 1'b1;
                    histCnt_q  <= histInc_d;
                    shiftRem_q <= shiftRem_q - 1'b1;
                    if (shiftRem_q == LC_W'(1)) begin
                        if (tokLast_q) begin
                            state_q <= ST_DONE;
                        end else if (eos_q) begin
                            state_q   <= ST_SEARCH;
                            cand_q    <= OFF_W'(histInc_d - 1'b1);
                            bestOff_q <= '0;
                            bestLen_q <= '0;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Self-checking bench for lz77_stream_encoder: directed vector table,
// hand-written backpressure and mid-stream reset sequences, and random
// streams checked against a plain-arithmetic LZ77 reference model.
module tb_lz77_stream_encoder;
    import lz77_pkg::*;

    localparam int SEARCH_LEN = 9;
    localparam int LOOK_LEN   = 8;
    localparam logic [7:0] EOS = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       tok_valid;
    logic       tok_ready = 1'b0;
    logic [3:0] tok_offset;
    logic [2:0] tok_len;
    logic [7:0] tok_char;
    logic       tok_last;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] stim[$];
    token_t     gotQ[$];
    token_t     expQ[$];

    typedef struct packed {
        logic [11:0][7:0] syms;
        logic [7:0]       n;
        logic [1:0]       gapMode;
        logic [3:0]       nTok;
        token_t [5:0]     exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    lz77_stream_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .tok_valid_o (tok_valid),
        .tok_ready_i (tok_ready),
        .tok_offset_o(tok_offset),
        .tok_len_o   (tok_len),
        .tok_char_o  (tok_char),
        .tok_last_o  (tok_last),
        .done_o      (done)
    );

    function automatic token_t mkTok(input int off, input int len, input logic [7:0] c, input logic last);
        token_t t;
        t.offset = 4'(off);
        t.len    = 3'(len);
        t.chr    = c;
        t.last   = last;
        return t;
    endfunction

    function automatic vec_t mkVec(input string s, input int gap, input int nTok);
        vec_t v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v.syms[i] = s[i];
        v.n       = 8'(s.len());
        v.gapMode = 2'(gap);
        v.nTok    = 4'(nTok);
        return v;
    endfunction

    function automatic token_t curTok();
        return token_t'({tok_offset, tok_len, tok_char, tok_last});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic loadStim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        tok_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tok_valid"}, 32'(tok_valid), 32'd0);
        checkOutput({tag, "_tok_offset"}, 32'(tok_offset), 32'd0);
        checkOutput({tag, "_tok_len"}, 32'(tok_len), 32'd0);
        checkOutput({tag, "_tok_char"}, 32'(tok_char), 32'd0);
        checkOutput({tag, "_tok_last"}, 32'(tok_last), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // LZ77 reference: history is simply everything before pos (capped at
    // SEARCH_LEN), and the usable match length is capped by the lookahead
    // depth and by what remains of the stream.
    task automatic buildExpected();
        int pos, n, histAvail, lmax, bestLen, bestOff, l;
        logic [7:0] ch;
        expQ.delete();
        n   = stim.size();
        pos = 0;
        while (pos < n) begin
            histAvail = (pos < SEARCH_LEN) ? pos : SEARCH_LEN;
            lmax      = (LOOK_LEN - 1 < n - pos) ? LOOK_LEN - 1 : n - pos;
            bestLen   = 0;
            bestOff   = 0;
            for (int off = histAvail - 1; off >= 0; off--) begin
                l = 0;
                while (l < lmax && stim[pos - 1 - off + l] == stim[pos + l]) l++;
                if (l > bestLen) begin
                    bestLen = l;
                    bestOff = off;
                end
            end
            ch = (pos + bestLen < n) ? stim[pos + bestLen] : EOS;
            expQ.push_back(mkTok(bestOff, bestLen, ch, (pos + bestLen + 1) >= n));
            pos += bestLen + 1;
        end
    endtask

    task automatic driveCycle(input int gapMode, input int readyMode, input int idx, input int cycles);
        logic gate;
        case (gapMode)
            0:       gate = 1'b1;
            1:       gate = (cycles % 2 == 0);
            default: gate = 1'($urandom_range(0, 1));
        endcase
        in_valid = (idx < stim.size()) && gate;
        in_data  = '0;
        if (idx < stim.size()) in_data = stim[idx];
        in_last  = (idx == stim.size() - 1);
        tok_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Streams stim into the DUT and collects tokens until done or a cycle budget.
    task automatic applyStimulus(input int gapMode, input int readyMode);
        int idx, cycles;
        idx    = 0;
        cycles = 0;
        gotQ.delete();
        driveCycle(gapMode, readyMode, idx, cycles);
        while (!done && cycles < 5000) begin
            @(negedge clk);
            if (tok_valid && tok_ready) gotQ.push_back(curTok());
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cycles++;
            driveCycle(gapMode, readyMode, idx, cycles);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        checkOutput("done_reached", 32'(done), 32'd1);
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        checkOutput("done_tok_valid", 32'(tok_valid), 32'd0);
    endtask

    task automatic compareTokens(input string tag);
        checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_tok%0d", tag, i),
                        (i < gotQ.size()) ? {16'h0, gotQ[i]} : 32'hDEAD_0000,
                        {16'h0, expQ[i]});
        end
    endtask

    task automatic feedStream();
        int w;
        logic acc;
        for (int i = 0; i < stim.size(); i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = (i == stim.size() - 1);
            w   = 0;
            acc = 1'b0;
            while (!acc && w < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                w++;
            end
            checkOutput($sformatf("feed_accept%0d", i), 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitTokValid(input string name);
        int w;
        w = 0;
        while (!tok_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput(name, 32'(tok_valid), 32'd1);
    endtask

    initial begin
        token_t held;
        int     accepted, w;
        logic   hs;

        vecs[0] = mkVec("ABCD", 0, 4);
        vecs[0].exp[0] = mkTok(0, 0, "A", 1'b0);
        vecs[0].exp[1] = mkTok(0, 0, "B", 1'b0);
        vecs[0].exp[2] = mkTok(0, 0, "C", 1'b0);
        vecs[0].exp[3] = mkTok(0, 0, "D", 1'b1);
        vecs[1] = mkVec("AAAAAAAAAA", 0, 3);
        vecs[1].exp[0] = mkTok(0, 0, "A", 1'b0);
        vecs[1].exp[1] = mkTok(0, 7, "A", 1'b0);
        vecs[1].exp[2] = mkTok(8, 1, EOS, 1'b1);
        vecs[2] = mkVec("ABCXABCD", 0, 5);
        vecs[2].exp[0] = mkTok(0, 0, "A", 1'b0);
        vecs[2].exp[1] = mkTok(0, 0, "B", 1'b0);
        vecs[2].exp[2] = mkTok(0, 0, "C", 1'b0);
        vecs[2].exp[3] = mkTok(0, 0, "X", 1'b0);
        vecs[2].exp[4] = mkTok(3, 3, "D", 1'b1);
        vecs[3] = vecs[2];
        vecs[3].gapMode = 2'd1;
        vecs[4] = mkVec("Z", 0, 1);
        vecs[4].exp[0] = mkTok(0, 0, "Z", 1'b1);

        #1;
        checkResetOutputs("reset");
        doReset();

        // Directed vector table
        for (int v = 0; v < 5; v++) begin
            doReset();
            stim.delete();
            for (int i = 0; i < int'(vecs[v].n); i++) stim.push_back(vecs[v].syms[i]);
            expQ.delete();
            for (int i = 0; i < int'(vecs[v].nTok); i++) expQ.push_back(vecs[v].exp[i]);
            applyStimulus(int'(vecs[v].gapMode), 0);
            compareTokens($sformatf("vec%0d", v));
        end

        // Backpressure: token held stable, exactly one accepted on a one-cycle release
        $display("[TB] backpressure sequence");
        doReset();
        loadStim("ABCD");
        tok_ready = 1'b0;
        feedStream();
        waitTokValid("bp_valid");
        held = curTok();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold%0d", k), {16'h0, curTok()}, {16'h0, held});
            checkOutput($sformatf("bp_hold_valid%0d", k), 32'(tok_valid), 32'd1);
        end
        checkOutput("bp_first", {16'h0, held}, {16'h0, mkTok(0, 0, "A", 1'b0)});
        accepted  = 0;
        tok_ready = 1'b1;
        @(negedge clk);
        if (tok_valid && tok_ready) accepted++;
        @(posedge clk); #1;
        tok_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (tok_valid && tok_ready) accepted++;
            @(posedge clk); #1;
        end
        checkOutput("bp_one_token", 32'(accepted), 32'd1);
        waitTokValid("bp_second_valid");
        checkOutput("bp_second", {16'h0, curTok()}, {16'h0, mkTok(0, 0, "B", 1'b0)});

        // Reset while the second token is being searched, then a fresh stream
        $display("[TB] mid-search reset sequence");
        doReset();
        loadStim("ABCXABCD");
        tok_ready = 1'b1;
        feedStream();
        w  = 0;
        hs = 1'b0;
        while (!hs && w < 100) begin
            @(negedge clk);
            hs = tok_valid && tok_ready;
            if (!hs) begin
                @(posedge clk); #1;
            end
            w++;
        end
        checkOutput("mr_first_handshake", 32'(hs), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkResetOutputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        loadStim("ABCD");
        expQ.delete();
        for (int i = 0; i < 4; i++) expQ.push_back(vecs[0].exp[i]);
        applyStimulus(0, 0);
        compareTokens("after_reset");

        // Random streams against the reference model
        for (int r = 0; r < 25; r++) begin
            int n, alpha;
            doReset();
            n     = $urandom_range(1, 40);
            alpha = $urandom_range(1, 3);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'h41 + 8'($urandom_range(0, alpha - 1)));
            buildExpected();
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 1));
            compareTokens($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
